// File: rtl/uart_wb_pkg.sv
// Register map and bit positions shared by the UART RX FIFO Wishbone slave.
// Constants only; no logic, no latency, no flow control.
package uart_wb_pkg;
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_COUNT  = 2'd3;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVR   = 2;

    localparam int CT_IRQEN  = 0;
    localparam int CT_FLUSH  = 1;
    localparam int CT_OVRCLR = 2;
endpackage

// File: rtl/uart_rx_fifo_wb_if.sv
// Wishbone classic 8-bit bus between host interconnect and the RX FIFO slave.
// Plain wires; the slave acks one cycle after a request, no backpressure beyond ack.
interface uart_rx_fifo_wb_if;
    logic       wb_cyc_i;
    logic       wb_stb_i;
    logic       wb_we_i;
    logic [1:0] wb_adr_i;
    logic [7:0] wb_dat_i;
    logic [7:0] wb_dat_o;
    logic       wb_ack_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/sync_fifo.sv
// Circular FIFO with registered pointers/count; dout shows the head combinationally.
// Push on full is ignored unless a pop happens in the same cycle; flush overrides both.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    // Count tops out at DEPTH = 2**PTR_W, so the MSB alone marks full.
    assign full    = count_q[PTR_W];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rptr_q];
    assign count   = count_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + PTR_W'(1);
            if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wptr_q] <= din;
    end
endmodule

// File: rtl/uart_rx_fifo_wb.sv
// Buffers UART RX bytes in a FIFO and serves them over a 4-register Wishbone slave.
// Ack one cycle after request, no wait states; bytes arriving while full are dropped and flagged.
module uart_rx_fifo_wb
    import uart_wb_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              rx_data,
    input  logic                    rx_done,
    uart_rx_fifo_wb_if.slave        wb,
    output logic                    irq
);
    localparam int PTR_W = $clog2(DEPTH);

    logic             ack_q;
    logic [7:0]       dat_q, dat_d;
    logic             ovr_q, ovr_d;
    logic             irq_en_q, irq_en_d;

    logic             req, rd_req, wr_ctrl;
    logic             pop, push, flush, drop;
    logic [7:0]       fifo_dout;
    logic             fifo_empty, fifo_full;
    logic [PTR_W:0]   fifo_count;

    // The ~ack_q term turns a held strobe into one access every second cycle.
    assign req     = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
    assign rd_req  = req & ~wb.wb_we_i;
    assign wr_ctrl = req & wb.wb_we_i & (wb.wb_adr_i == ADDR_CTRL);
    assign pop     = rd_req & (wb.wb_adr_i == ADDR_DATA) & ~fifo_empty;
    assign flush   = wr_ctrl & wb.wb_dat_i[CT_FLUSH];
    assign push    = rx_done & (~fifo_full | pop) & ~flush;
    assign drop    = rx_done & fifo_full & ~pop & ~flush;

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (rx_data),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    always_comb begin
        dat_d    = dat_q;
        ovr_d    = ovr_q;
        irq_en_d = irq_en_q;
        if (rd_req) begin
            case (wb.wb_adr_i)
                ADDR_DATA:   dat_d = fifo_empty ? 8'h00 : fifo_dout;
                ADDR_STATUS: dat_d = {5'b0, ovr_q, fifo_full, fifo_empty};
                ADDR_CTRL:   dat_d = {7'b0, irq_en_q};
                default:     dat_d = 8'(fifo_count);
            endcase
        end
        if (wr_ctrl) begin
            irq_en_d = wb.wb_dat_i[CT_IRQEN];
            if (wb.wb_dat_i[CT_OVRCLR]) ovr_d = 1'b0;
        end
        if (drop) ovr_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q    <= 1'b0;
            dat_q    <= 8'h00;
            ovr_q    <= 1'b0;
            irq_en_q <= 1'b0;
        end else begin
            ack_q    <= req;
            dat_q    <= dat_d;
            ovr_q    <= ovr_d;
            irq_en_q <= irq_en_d;
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = dat_q;
    assign irq         = irq_en_q & ~fifo_empty;
endmodule

// File: tb/tb_uart_rx_fifo_wb.sv
// Bench for uart_rx_fifo_wb: directed vector table, hand-written corner sequences,
// and random traffic checked against a queue-based model of the register map.
module tb_uart_rx_fifo_wb;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       irq;

    uart_rx_fifo_wb_if wb();

    uart_rx_fifo_wb #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx_data (rx_data),
        .rx_done (rx_done),
        .wb      (wb),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] mq[$];
    logic       m_ovr = 1'b0;
    logic       m_irqen = 1'b0;
    logic [7:0] m_dat = 8'h00;

    typedef struct {
        bit         is_push;
        logic       we;
        logic [1:0] adr;
        logic [7:0] wd;
        logic       rx_en;
        logic [7:0] rx_b;
        logic [7:0] expv;
    } vec_t;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, expv);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, expv);
        end
    endtask

    function automatic logic [7:0] m_status();
        return {5'b0, m_ovr, mq.size() == DEPTH, mq.size() == 0};
    endfunction

    function automatic logic m_irq();
        return m_irqen && (mq.size() != 0);
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_ovr   = 1'b0;
        m_irqen = 1'b0;
        m_dat   = 8'h00;
    endfunction

    // One bus access with an optional same-cycle received byte; returns wb_dat_o after it.
    function automatic logic [7:0] model_acc(input logic we, input logic [1:0] adr,
                                             input logic [7:0] wd, input logic rx_en,
                                             input logic [7:0] rx_b);
        logic flushed;
        flushed = 1'b0;
        if (!we) begin
            case (adr)
                2'd0:    m_dat = (mq.size() > 0) ? mq.pop_front() : 8'h00;
                2'd1:    m_dat = m_status();
                2'd2:    m_dat = {7'b0, m_irqen};
                default: m_dat = 8'(mq.size());
            endcase
        end else if (adr == 2'd2) begin
            m_irqen = wd[0];
            if (wd[2]) m_ovr = 1'b0;
            if (wd[1]) begin
                mq.delete();
                flushed = 1'b1;
            end
        end
        if (rx_en && !flushed) begin
            if (mq.size() < DEPTH) mq.push_back(rx_b);
            else m_ovr = 1'b1;
        end
        return m_dat;
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic acc(input logic we, input logic [1:0] adr, input logic [7:0] wd,
                       input logic rx_en, input logic [7:0] rx_b, output logic [7:0] rd);
        logic [7:0] expv;
        int lat;
        expv = model_acc(we, adr, wd, rx_en, rx_b);
        lat = 0;
        wb.wb_cyc_i = 1'b1;
        wb.wb_stb_i = 1'b1;
        wb.wb_we_i  = we;
        wb.wb_adr_i = adr;
        wb.wb_dat_i = wd;
        rx_done = rx_en;
        rx_data = rx_b;
        do begin
            @(posedge clk); #1;
            rx_done = 1'b0;
            lat++;
        end while (!wb.wb_ack_o && lat < 8);
        chk("ack_latency", 8'(lat), 8'd1);
        rd = wb.wb_dat_o;
        chk($sformatf("dat_o we=%0d adr=%0d", we, adr), rd, expv);
        chk1("irq_after_access", irq, m_irq());
        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
        wb.wb_we_i  = 1'b0;
        @(posedge clk); #1;
        chk1("ack_single", wb.wb_ack_o, 1'b0);
    endtask

    task automatic push(input logic [7:0] b);
        if (mq.size() < DEPTH) mq.push_back(b);
        else m_ovr = 1'b1;
        rx_done = 1'b1;
        rx_data = b;
        @(posedge clk); #1;
        rx_done = 1'b0;
        chk1("irq_after_push", irq, m_irq());
    endtask

    initial begin
        vec_t       tbl[14];
        logic [7:0] rd;
        int         acks;
        int         k;
        logic       r_we;
        logic [1:0] r_adr;
        logic [7:0] r_wd;

        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
        wb.wb_we_i  = 1'b0;
        wb.wb_adr_i = 2'd0;
        wb.wb_dat_i = 8'h00;

        #12;
        chk1("reset_ack", wb.wb_ack_o, 1'b0);
        chk("reset_dat", wb.wb_dat_o, 8'h00);
        chk1("reset_irq", irq, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        //          push we adr   wd    rx  rx_b   expected dat_o
        tbl[0]  = '{1, 0, 2'd0, 8'h00, 0, 8'h41, 8'h00};
        tbl[1]  = '{1, 0, 2'd0, 8'h00, 0, 8'h42, 8'h00};
        tbl[2]  = '{1, 0, 2'd0, 8'h00, 0, 8'h43, 8'h00};
        tbl[3]  = '{0, 0, 2'd0, 8'h00, 0, 8'h00, 8'h41};
        tbl[4]  = '{0, 0, 2'd0, 8'h00, 0, 8'h00, 8'h42};
        tbl[5]  = '{0, 0, 2'd0, 8'h00, 0, 8'h00, 8'h43};
        tbl[6]  = '{0, 0, 2'd1, 8'h00, 0, 8'h00, 8'h01};
        tbl[7]  = '{0, 0, 2'd0, 8'h00, 0, 8'h00, 8'h00};
        tbl[8]  = '{0, 0, 2'd3, 8'h00, 0, 8'h00, 8'h00};
        tbl[9]  = '{0, 0, 2'd0, 8'h00, 1, 8'h55, 8'h00};
        tbl[10] = '{0, 0, 2'd3, 8'h00, 0, 8'h00, 8'h01};
        tbl[11] = '{0, 0, 2'd0, 8'h00, 0, 8'h00, 8'h55};
        tbl[12] = '{0, 1, 2'd2, 8'h01, 0, 8'h00, 8'h55};
        tbl[13] = '{0, 0, 2'd2, 8'h00, 0, 8'h00, 8'h01};

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].is_push) push(tbl[i].rx_b);
            else begin
                acc(tbl[i].we, tbl[i].adr, tbl[i].wd, tbl[i].rx_en, tbl[i].rx_b, rd);
                chk($sformatf("vec%0d", i), rd, tbl[i].expv);
            end
        end

        // Interrupt follows irq_en & ~empty
        chk1("irq_empty", irq, 1'b0);
        push(8'h10);
        chk1("irq_set", irq, 1'b1);
        acc(0, 2'd0, 8'h00, 0, 8'h00, rd);
        chk("irq_pop_data", rd, 8'h10);
        chk1("irq_clear", irq, 1'b0);
        for (int i = 1; i <= 5; i++) push(8'(i));
        acc(1, 2'd2, 8'h03, 0, 8'h00, rd);
        acc(0, 2'd3, 8'h00, 0, 8'h00, rd);
        chk("flush_count", rd, 8'h00);
        chk1("flush_irq", irq, 1'b0);
        acc(0, 2'd2, 8'h00, 0, 8'h00, rd);
        chk("ctrl_after_flush", rd, 8'h01);

        // Fill, overflow, clear overrun
        acc(1, 2'd2, 8'h00, 0, 8'h00, rd);
        for (int i = 0; i < DEPTH; i++) push(8'(i));
        acc(0, 2'd1, 8'h00, 0, 8'h00, rd);
        chk("full_status", rd, 8'h02);
        acc(0, 2'd3, 8'h00, 0, 8'h00, rd);
        chk("full_count", rd, 8'd16);
        push(8'hFF);
        acc(0, 2'd1, 8'h00, 0, 8'h00, rd);
        chk("overrun_status", rd, 8'h06);
        acc(1, 2'd2, 8'h04, 0, 8'h00, rd);
        acc(0, 2'd1, 8'h00, 0, 8'h00, rd);
        chk("ovr_cleared_status", rd, 8'h02);

        // Pop and push together while full
        acc(0, 2'd0, 8'h00, 1, 8'hAA, rd);
        chk("full_pushpop_data", rd, 8'h00);
        acc(0, 2'd3, 8'h00, 0, 8'h00, rd);
        chk("full_pushpop_count", rd, 8'd16);
        acc(0, 2'd1, 8'h00, 0, 8'h00, rd);
        chk("full_pushpop_status", rd, 8'h02);
        for (int i = 0; i < DEPTH; i++) acc(0, 2'd0, 8'h00, 0, 8'h00, rd);
        chk("last_of_16", rd, 8'hAA);
        acc(0, 2'd1, 8'h00, 0, 8'h00, rd);
        chk("drained_status", rd, 8'h01);

        // Overrun clear and overflow in the same cycle: set wins
        for (int i = 0; i < DEPTH; i++) push(8'(8'h80 + i));
        acc(1, 2'd2, 8'h04, 1, 8'h77, rd);
        acc(0, 2'd1, 8'h00, 0, 8'h00, rd);
        chk("ovr_set_wins", rd, 8'h06);
        // Flush beats a same-cycle push and leaves overrun alone
        acc(1, 2'd2, 8'h02, 1, 8'h88, rd);
        acc(0, 2'd3, 8'h00, 0, 8'h00, rd);
        chk("flush_vs_push_count", rd, 8'h00);
        acc(0, 2'd1, 8'h00, 0, 8'h00, rd);
        chk("flush_keeps_ovr", rd, 8'h05);
        acc(1, 2'd2, 8'h04, 0, 8'h00, rd);

        // Strobe held high: one ack every second cycle
        push(8'h3C);
        wb.wb_cyc_i = 1'b1;
        wb.wb_stb_i = 1'b1;
        wb.wb_we_i  = 1'b0;
        wb.wb_adr_i = 2'd1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (wb.wb_ack_o) acks++;
        end
        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
        m_dat = m_status();
        chk("held_stb_acks", 8'(acks), 8'd3);
        chk("held_stb_dat", wb.wb_dat_o, m_dat);
        @(posedge clk); #1;

        // Strobe without cycle is not an access
        wb.wb_stb_i = 1'b1;
        wb.wb_adr_i = 2'd0;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (wb.wb_ack_o) acks++;
        end
        wb.wb_stb_i = 1'b0;
        chk("stb_no_cyc_acks", 8'(acks), 8'd0);
        acc(0, 2'd3, 8'h00, 0, 8'h00, rd);
        chk("stb_no_cyc_count", rd, 8'd1);
        acc(0, 2'd0, 8'h00, 0, 8'h00, rd);
        chk("stb_no_cyc_data", rd, 8'h3C);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(0, 9);
            if (k < 4) push(8'($urandom));
            else begin
                r_we  = ($urandom_range(0, 3) == 0);
                r_adr = 2'($urandom);
                r_wd  = 8'($urandom);
                if (r_we && r_adr == 2'd2 && $urandom_range(0, 3) != 0) r_wd[1] = 1'b0;
                acc(r_we, r_adr, r_wd, ($urandom_range(0, 2) == 0), 8'($urandom), rd);
            end
        end

        // Reset in the middle of an acked access
        acc(1, 2'd2, 8'h03, 0, 8'h00, rd);
        push(8'h01);
        push(8'h02);
        push(8'h03);
        chk1("pre_reset_irq", irq, 1'b1);
        wb.wb_cyc_i = 1'b1;
        wb.wb_stb_i = 1'b1;
        wb.wb_we_i  = 1'b0;
        wb.wb_adr_i = 2'd3;
        @(posedge clk); #1;
        chk1("pre_reset_ack", wb.wb_ack_o, 1'b1);
        chk("pre_reset_count", wb.wb_dat_o, 8'd3);
        #2;
        rst_n = 1'b0;
        rx_done = 1'b1;
        rx_data = 8'hEE;
        #1;
        chk1("reset_async_ack", wb.wb_ack_o, 1'b0);
        chk1("reset_async_irq", irq, 1'b0);
        chk("reset_async_dat", wb.wb_dat_o, 8'h00);
        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rx_done = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_dat", wb.wb_dat_o, 8'h00);
        acc(0, 2'd3, 8'h00, 0, 8'h00, rd);
        chk("post_reset_count", rd, 8'h00);
        acc(0, 2'd1, 8'h00, 0, 8'h00, rd);
        chk("post_reset_status", rd, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
